// File: rtl/multicycle_main_control_if.sv
// Control bundle between the multi-cycle MIPS main controller and its datapath.
// master = controller side (drives enables/selects), slave = datapath side.
interface multicycle_main_control_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         opcode;
    logic               mem_ready;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               branch_ne;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               MemtoReg;
    logic               RegDst;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ALUOp;
    logic [1:0]         PCSource;
    logic               illegal_op;
    logic [STATE_W-1:0] state_dbg;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, branch_ne, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
               ALUOp, PCSource, illegal_op, state_dbg
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, branch_ne, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
               ALUOp, PCSource, illegal_op, state_dbg
    );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath (fetch/decode/execute/mem/wb).
// Define MULTICYCLE_BNE_EN to add the bne state; otherwise opcode 000101 is illegal.
module multicycle_main_control #(
    parameter int STATE_W = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_main_control_if.master   bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = STATE_W'(0),
        S_FETCH    = STATE_W'(1),
        S_DECODE   = STATE_W'(2),
        S_MEMADR   = STATE_W'(3),
        S_MEMRD    = STATE_W'(4),
        S_MEMWB    = STATE_W'(5),
        S_MEMWR    = STATE_W'(6),
        S_RTYPE_EX = STATE_W'(7),
        S_RTYPE_WB = STATE_W'(8),
        S_BRANCH   = STATE_W'(9),
        S_ADDI_EX  = STATE_W'(10),
        S_ADDI_WB  = STATE_W'(11),
        S_JUMP     = STATE_W'(12),
        S_BNE      = STATE_W'(13),
        S_ILLEGAL  = STATE_W'(15)
    } state_t;

    state_t state;
    state_t state_next;
    logic   illegal_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == S_ILLEGAL) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign bus.illegal_op = illegal_q;
    assign bus.state_dbg  = state;

    always_comb begin
        state_next      = state;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.branch_ne   = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.PCSource    = 2'b00;

        case (state)
            S_IDLE: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                // IR and PC load only on the cycle the read actually completes
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.ALUSrcB = 2'b11;
                case (bus.opcode)
                    OP_RTYPE:     state_next = S_RTYPE_EX;
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDI_EX;
                    OP_J:         state_next = S_JUMP;
`ifdef MULTICYCLE_BNE_EN
                    OP_BNE:       state_next = S_BNE;
`endif
                    default:      state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_next  = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.IorD    = 1'b1;
                bus.MemRead = 1'b1;
                if (bus.mem_ready) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
                state_next   = S_FETCH;
            end
            S_MEMWR: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
                if (bus.mem_ready) begin
                    state_next = S_FETCH;
                end
            end
            S_RTYPE_EX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
                state_next  = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
                state_next   = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 2'b01;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                state_next      = S_FETCH;
            end
            S_ADDI_EX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_next  = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                bus.RegWrite = 1'b1;
                state_next   = S_FETCH;
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
                state_next   = S_FETCH;
            end
`ifdef MULTICYCLE_BNE_EN
            S_BNE: begin
                // Same as beq, with the zero flag inverted on the PC load
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 2'b01;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                bus.branch_ne   = 1'b1;
                state_next      = S_FETCH;
            end
`endif
            S_ILLEGAL: begin
                state_next = S_ILLEGAL;
            end
            default: begin
                state_next = S_ILLEGAL;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed table-driven bench for multicycle_main_control, plus hand-written
// sequences for bne, reset abort during a memory wait and the illegal trap.
module tb_multicycle_main_control;

    localparam int STATE_W = 4;

    // Output vector layout: {PCWrite, PCWriteCond, branch_ne, IorD, MemRead,
    // MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0],
    // ALUOp[1:0], PCSource[1:0], illegal_op}
    localparam logic [17:0] M_PCW    = 18'd1 << 17;
    localparam logic [17:0] M_PCWC   = 18'd1 << 16;
    localparam logic [17:0] M_BNE    = 18'd1 << 15;
    localparam logic [17:0] M_IORD   = 18'd1 << 14;
    localparam logic [17:0] M_MRD    = 18'd1 << 13;
    localparam logic [17:0] M_MWR    = 18'd1 << 12;
    localparam logic [17:0] M_IRW    = 18'd1 << 11;
    localparam logic [17:0] M_M2R    = 18'd1 << 10;
    localparam logic [17:0] M_RDST   = 18'd1 << 9;
    localparam logic [17:0] M_RW     = 18'd1 << 8;
    localparam logic [17:0] M_SRCA   = 18'd1 << 7;
    localparam logic [17:0] SRCB_4   = 18'd1 << 5;
    localparam logic [17:0] SRCB_IMM = 18'd2 << 5;
    localparam logic [17:0] SRCB_SH  = 18'd3 << 5;
    localparam logic [17:0] OP_SUB   = 18'd1 << 3;
    localparam logic [17:0] OP_FN    = 18'd2 << 3;
    localparam logic [17:0] PCS_OUT  = 18'd1 << 1;
    localparam logic [17:0] PCS_J    = 18'd2 << 1;
    localparam logic [17:0] M_ILL    = 18'd1;

    localparam logic [17:0] O_IDLE   = 18'd0;
    localparam logic [17:0] O_FETCH0 = M_MRD | SRCB_4;
    localparam logic [17:0] O_FETCH1 = M_MRD | SRCB_4 | M_IRW | M_PCW;
    localparam logic [17:0] O_DECODE = SRCB_SH;
    localparam logic [17:0] O_MEMADR = M_SRCA | SRCB_IMM;
    localparam logic [17:0] O_MEMRD  = M_IORD | M_MRD;
    localparam logic [17:0] O_MEMWB  = M_M2R | M_RW;
    localparam logic [17:0] O_MEMWR  = M_IORD | M_MWR;
    localparam logic [17:0] O_RTEX   = M_SRCA | OP_FN;
    localparam logic [17:0] O_RTWB   = M_RDST | M_RW;
    localparam logic [17:0] O_BR     = M_SRCA | OP_SUB | M_PCWC | PCS_OUT;
    localparam logic [17:0] O_ADDIEX = M_SRCA | SRCB_IMM;
    localparam logic [17:0] O_ADDIWB = M_RW;
    localparam logic [17:0] O_JUMP   = M_PCW | PCS_J;
    localparam logic [17:0] O_BNE    = O_BR | M_BNE;
    localparam logic [17:0] O_ILL    = M_ILL;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] BAD  = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] out;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    multicycle_main_control_if #(.STATE_W(STATE_W)) bus ();

    multicycle_main_control #(.STATE_W(STATE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [17:0] ctl;
    assign ctl = {bus.PCWrite, bus.PCWriteCond, bus.branch_ne, bus.IorD,
                  bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg,
                  bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                  bus.ALUOp, bus.PCSource, bus.illegal_op};

    // Called just after a falling edge: drive, settle, compare, move to next falling edge.
    task automatic step(input string name, input logic r, input logic [5:0] op,
                        input logic rdy, input logic [3:0] est, input logic [17:0] eout);
        reset         = r;
        bus.opcode    = op;
        bus.mem_ready = rdy;
        #1;
        checks++;
        if (bus.state_dbg !== est) begin
            errors++;
            $display("FAIL %s state: got %0d expected %0d", name, bus.state_dbg, est);
        end
        checks++;
        if (ctl !== eout) begin
            errors++;
            $display("FAIL %s outputs: got %b expected %b", name, ctl, eout);
        end
        @(negedge clk);
    endtask

    initial begin
        // lw with mem_ready high except one fetch wait
        vecs.push_back('{1'b0, LW,   1'b1, 4'd0,  O_IDLE});
        vecs.push_back('{1'b0, LW,   1'b0, 4'd1,  O_FETCH0});
        vecs.push_back('{1'b0, LW,   1'b1, 4'd1,  O_FETCH1});
        vecs.push_back('{1'b0, LW,   1'b1, 4'd2,  O_DECODE});
        vecs.push_back('{1'b0, LW,   1'b1, 4'd3,  O_MEMADR});
        vecs.push_back('{1'b0, LW,   1'b1, 4'd4,  O_MEMRD});
        vecs.push_back('{1'b0, LW,   1'b1, 4'd5,  O_MEMWB});
        // sw with three wait cycles in MEMWR
        vecs.push_back('{1'b0, SW,   1'b1, 4'd1,  O_FETCH1});
        vecs.push_back('{1'b0, SW,   1'b1, 4'd2,  O_DECODE});
        vecs.push_back('{1'b0, SW,   1'b1, 4'd3,  O_MEMADR});
        vecs.push_back('{1'b0, SW,   1'b0, 4'd6,  O_MEMWR});
        vecs.push_back('{1'b0, SW,   1'b0, 4'd6,  O_MEMWR});
        vecs.push_back('{1'b0, SW,   1'b0, 4'd6,  O_MEMWR});
        vecs.push_back('{1'b0, SW,   1'b1, 4'd6,  O_MEMWR});
        // R-type with mem_ready low where it must be ignored
        vecs.push_back('{1'b0, RT,   1'b1, 4'd1,  O_FETCH1});
        vecs.push_back('{1'b0, RT,   1'b0, 4'd2,  O_DECODE});
        vecs.push_back('{1'b0, RT,   1'b0, 4'd7,  O_RTEX});
        vecs.push_back('{1'b0, RT,   1'b0, 4'd8,  O_RTWB});
        // beq, j, addi
        vecs.push_back('{1'b0, BEQ,  1'b1, 4'd1,  O_FETCH1});
        vecs.push_back('{1'b0, BEQ,  1'b1, 4'd2,  O_DECODE});
        vecs.push_back('{1'b0, BEQ,  1'b0, 4'd9,  O_BR});
        vecs.push_back('{1'b0, JMP,  1'b1, 4'd1,  O_FETCH1});
        vecs.push_back('{1'b0, JMP,  1'b1, 4'd2,  O_DECODE});
        vecs.push_back('{1'b0, JMP,  1'b0, 4'd12, O_JUMP});
        vecs.push_back('{1'b0, ADDI, 1'b1, 4'd1,  O_FETCH1});
        vecs.push_back('{1'b0, ADDI, 1'b1, 4'd2,  O_DECODE});
        vecs.push_back('{1'b0, ADDI, 1'b1, 4'd10, O_ADDIEX});
        vecs.push_back('{1'b0, ADDI, 1'b1, 4'd11, O_ADDIWB});

        reset         = 1'b1;
        bus.opcode    = 6'd0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].op, vecs[i].rdy,
                 vecs[i].st, vecs[i].out);
        end

        // bne: its own state when enabled, the illegal trap otherwise
        step("bne_fetch",  1'b0, BNE, 1'b1, 4'd1, O_FETCH1);
        step("bne_decode", 1'b0, BNE, 1'b1, 4'd2, O_DECODE);
`ifdef MULTICYCLE_BNE_EN
        step("bne_exec",   1'b0, BNE, 1'b1, 4'd13, O_BNE);
        step("bne_rst",    1'b1, BNE, 1'b0, 4'd1,  O_FETCH0);
`else
        step("bne_exec",   1'b0, BNE, 1'b1, 4'd15, O_ILL);
        step("bne_rst",    1'b1, BNE, 1'b0, 4'd15, O_ILL);
`endif
        step("bne_idle",   1'b0, RT,  1'b0, 4'd0, O_IDLE);

        // Reset during a store wait: no write strobe the cycle after
        step("ab_fetch",   1'b0, SW, 1'b1, 4'd1, O_FETCH1);
        step("ab_decode",  1'b0, SW, 1'b1, 4'd2, O_DECODE);
        step("ab_memadr",  1'b0, SW, 1'b1, 4'd3, O_MEMADR);
        step("ab_wait",    1'b0, SW, 1'b0, 4'd6, O_MEMWR);
        step("ab_rst",     1'b1, SW, 1'b0, 4'd6, O_MEMWR);
        step("ab_idle",    1'b0, SW, 1'b1, 4'd0, O_IDLE);

        // Illegal opcode: trapped for 20 cycles whatever mem_ready does, then reset
        step("il_fetch",   1'b0, BAD, 1'b1, 4'd1, O_FETCH1);
        step("il_decode",  1'b0, BAD, 1'b1, 4'd2, O_DECODE);
        for (int i = 0; i < 20; i++) begin
            step($sformatf("il_hold%0d", i), 1'b0, (i % 2 == 0) ? LW : RT,
                 logic'(i % 3 == 0), 4'd15, O_ILL);
        end
        step("il_rst",     1'b1, BAD, 1'b1, 4'd15, O_ILL);
        step("il_idle",    1'b0, BAD, 1'b1, 4'd0,  O_IDLE);
        step("il_refetch", 1'b0, BAD, 1'b1, 4'd1,  O_FETCH1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
